fetch_unit: RTL and testbench

Instruction fetch stage of the MIPS datapath, directly upstream of the instruction memory and decode. Holds the PC and drives the word address into the combinational instruction memory, which is 2048 words indexed by addr[12:2] and flags misaligned addresses. Captures each returned instruction with its PC and exception flag in a 2-entry queue, and hands entries to decode over a valid/ready handshake. Accepts branch/jump and exception redirects that flush in-flight work.

---
 rtl/fetch_unit.sv | 141 ++++++++++++++
 tb/tb_fetch_unit.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: holds the PC, captures each fetched word in a
// 2-entry queue and hands the head entry to decode over valid/ready.
//
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   imem_addr           fetch address (the PC register)
//   imem_dout/imem_exc  combinational instruction word / misaligned flag
//   redirect_valid/pc   branch or jump target for this cycle
//   exc_redirect        exception taken; jump to EXC_VECTOR
//   out_*               head entry of the queue with valid/ready handshake
//   fetch_count         number of completed out handshakes (wraps)
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0180
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_dout,
    input  logic        imem_exc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        exc_redirect,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic [31:0] out_pc,
    output logic [31:0] out_pc4,
    output logic        out_exc,
    output logic [31:0] fetch_count
);

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    // pc4 is stored rather than derived so out_pc4 is a pure register output.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] inst;
        logic        exc;
    } entry_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [1:0]  count_q, count_d;
    entry_t      head_q, head_d;
    entry_t      tail_q, tail_d;
    logic [31:0] fetch_count_q, fetch_count_d;

    logic   redirect_any;
    logic   pop;
    logic   fetch_en;
    entry_t new_e;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        count_d       = count_q;
        head_d        = head_q;
        tail_d        = tail_q;
        fetch_count_d = fetch_count_q;

        redirect_any = exc_redirect || redirect_valid;
        pop          = (count_q != 2'd0) && out_ready;
        fetch_en     = (state_q == RUN) && !redirect_any
                       && ((count_q != 2'd2) || pop);

        new_e.pc   = pc_q;
        new_e.pc4  = pc_q + 32'd4;
        new_e.inst = imem_exc ? 32'd0 : imem_dout;
        new_e.exc  = imem_exc;

        // A pop still completes during a redirect; decode kills it.
        if (pop) begin
            fetch_count_d = fetch_count_q + 32'd1;
        end

        if (redirect_any) begin
            count_d = 2'd0;
            pc_d    = exc_redirect ? EXC_VECTOR : redirect_pc;
            state_d = RUN;
        end else begin
            // Head is always slot 0; a pop shifts the tail forward.
            if (pop && fetch_en) begin
                if (count_q == 2'd2) begin
                    head_d = tail_q;
                    tail_d = new_e;
                end else begin
                    head_d = new_e;
                end
            end else if (fetch_en) begin
                if (count_q == 2'd0) begin
                    head_d = new_e;
                end else begin
                    tail_d = new_e;
                end
                count_d = count_q + 2'd1;
            end else if (pop) begin
                head_d  = tail_q;
                count_d = count_q - 2'd1;
            end

            if (fetch_en) begin
                pc_d = pc_q + 32'd4;
                if (imem_exc) begin
                    state_d = HALT;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= RUN;
            pc_q          <= RESET_PC;
            count_q       <= 2'd0;
            head_q        <= '0;
            tail_q        <= '0;
            fetch_count_q <= 32'd0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            count_q       <= count_d;
            head_q        <= head_d;
            tail_q        <= tail_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    assign imem_addr   = pc_q;
    assign out_valid   = (count_q != 2'd0);
    assign out_inst    = head_q.inst;
    assign out_pc      = head_q.pc;
    assign out_pc4     = head_q.pc4;
    assign out_exc     = head_q.exc;
    assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a word-k-holds-k instruction memory.
// Each check is a hand-computed expectation applied 1ns after the edge.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] imem_addr;
    logic [31:0] imem_dout;
    logic        imem_exc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        exc_redirect;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic [31:0] out_pc4;
    logic        out_exc;
    logic [31:0] fetch_count;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    assign imem_dout = {21'd0, imem_addr[12:2]};
    assign imem_exc  = (imem_addr[1:0] != 2'b00);

    fetch_unit dut (
        .clk            (clk),
        .rst            (rst),
        .imem_addr      (imem_addr),
        .imem_dout      (imem_dout),
        .imem_exc       (imem_exc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .exc_redirect   (exc_redirect),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_inst       (out_inst),
        .out_pc         (out_pc),
        .out_pc4        (out_pc4),
        .out_exc        (out_exc),
        .fetch_count    (fetch_count)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        exc_redirect   = 1'b0;
        out_ready      = 1'b0;

        // Reset state
        do_reset();
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_inst", out_inst, 32'd0);
        chk("rst_pc", out_pc, 32'd0);
        chk("rst_pc4", out_pc4, 32'd0);
        chk("rst_exc", {31'd0, out_exc}, 32'd0);
        chk("rst_fc", fetch_count, 32'd0);

        // Streaming with out_ready=1
        out_ready = 1'b1;
        tick();
        chk("s0_valid", {31'd0, out_valid}, 32'd1);
        chk("s0_pc", out_pc, 32'h0);
        chk("s0_inst", out_inst, 32'd0);
        chk("s0_pc4", out_pc4, 32'h4);
        for (int k = 1; k <= 3; k++) begin
            tick();
            chk("s_pc", out_pc, 32'(4 * k));
            chk("s_inst", out_inst, 32'(k));
            chk("s_fc", fetch_count, 32'(k));
        end

        // Backpressure
        out_ready = 1'b0;
        do_reset();
        for (int k = 0; k < 6; k++) tick();
        chk("bp_addr", imem_addr, 32'h8);
        chk("bp_head", out_pc, 32'h0);
        chk("bp_valid", {31'd0, out_valid}, 32'd1);
        chk("bp_fc", fetch_count, 32'd0);
        out_ready = 1'b1;
        tick();
        chk("bp_r1_pc", out_pc, 32'h4);
        chk("bp_r1_fc", fetch_count, 32'd1);
        tick();
        chk("bp_r2_pc", out_pc, 32'h8);
        chk("bp_r2_fc", fetch_count, 32'd2);
        tick();
        chk("bp_r3_pc", out_pc, 32'hC);

        // Simultaneous exception and branch redirect
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        exc_redirect   = 1'b1;
        tick();
        redirect_valid = 1'b0;
        exc_redirect   = 1'b0;
        chk("ex_n1_valid", {31'd0, out_valid}, 32'd0);
        chk("ex_n1_addr", imem_addr, 32'h180);
        chk("ex_n1_fc", fetch_count, 32'd4);
        tick();
        chk("ex_n2_valid", {31'd0, out_valid}, 32'd1);
        chk("ex_n2_pc", out_pc, 32'h180);
        chk("ex_n2_pc4", out_pc4, 32'h184);
        chk("ex_n2_inst", out_inst, 32'h60);
        tick();
        chk("ex_n3_pc", out_pc, 32'h184);

        // Misaligned redirect target halts fetch
        redirect_valid = 1'b1;
        redirect_pc    = 32'h42;
        tick();
        redirect_valid = 1'b0;
        chk("mis_addr", imem_addr, 32'h42);
        tick();
        chk("mis_valid", {31'd0, out_valid}, 32'd1);
        chk("mis_pc", out_pc, 32'h42);
        chk("mis_exc", {31'd0, out_exc}, 32'd1);
        chk("mis_inst", out_inst, 32'd0);
        for (int k = 0; k < 10; k++) tick();
        chk("halt_valid", {31'd0, out_valid}, 32'd0);
        chk("halt_addr", imem_addr, 32'h46);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        tick();
        redirect_valid = 1'b0;
        tick();
        chk("res_pc", out_pc, 32'h100);
        chk("res_inst", out_inst, 32'h40);
        chk("res_exc", {31'd0, out_exc}, 32'd0);

        // Reset while halted with a queued entry
        out_ready      = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h42;
        tick();
        redirect_valid = 1'b0;
        tick();
        tick();
        chk("hr_pre_valid", {31'd0, out_valid}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("hr_valid", {31'd0, out_valid}, 32'd0);
        chk("hr_addr", imem_addr, 32'h0);
        out_ready = 1'b1;
        tick();
        chk("hr_s0_pc", out_pc, 32'h0);
        tick();
        chk("hr_s1_pc", out_pc, 32'h4);

        // fetch_count wrap
        out_ready = 1'b0;
        @(negedge clk);
        force dut.fetch_count_q = 32'hFFFF_FFFF;
        #1;
        release dut.fetch_count_q;
        chk("wrap_pre", fetch_count, 32'hFFFF_FFFF);
        out_ready = 1'b1;
        tick();
        chk("wrap_fc", fetch_count, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
